// File: rtl/det_pkg.sv
// Shared types and constants for the determinant matrix memory.
package det_pkg;

  localparam int DATA_W    = 20;
  localparam int RES_W     = 40;
  localparam int MAX_N_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_HDR   = 3'd2,
    ST_SERVE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/det_mat_ram.sv
// Matrix entry storage: synchronous write, asynchronous read, no reset.
module det_mat_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 20
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  // Host load port writes one entry per accepted word.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/det_mat_mem.sv
// Matrix memory front-end for a determinant engine: host loads N and the
// N*N entries, the engine reads them back by (i,j) and returns one result.
// Optional feature macro: DET_MAT_MEM_CYCLE_CNT_EN builds the engine cycle
// counter; without it cycle_count is tied to zero.
//
// state | meaning
// IDLE  | waiting for a dimension word, engine held in reset
// LOAD  | accepting N*N row-major entries
// HDR   | one cycle, engine released, read_data returns N
// SERVE | engine reads entries by (i,j) until finish&&write
// DONE  | result held until result_ack, engine back in reset
module det_mat_mem
  import det_pkg::*;
#(
  parameter int MAX_N = MAX_N_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  output logic              eng_reset,
  input  logic [DATA_W-1:0] i,
  input  logic [DATA_W-1:0] j,
  input  logic              read,
  input  logic              write,
  output logic [DATA_W-1:0] read_data,
  input  logic [RES_W-1:0]  write_data,
  input  logic              finish,
  output logic [RES_W-1:0]  result,
  output logic              result_valid,
  input  logic              result_ack,
  output logic              load_err,
  output logic              addr_err,
  output logic [31:0]       cycle_count
);

  localparam int IW    = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam int DEPTH = MAX_N * MAX_N;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] n_q, n_d;
  logic [IW-1:0]     row_q, row_d;
  logic [IW-1:0]     col_q, col_d;
  logic [RES_W-1:0]  result_q, result_d;
  logic              result_valid_q, result_valid_d;
  logic              load_err_q, load_err_d;
  logic              addr_err_q, addr_err_d;
  logic              load_ready_q, load_ready_d;
  logic              eng_reset_q, eng_reset_d;

  logic              ram_we;
  logic [AW-1:0]     ram_waddr;
  logic [AW-1:0]     ram_raddr;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] n_m1;
  logic              last_col;
  logic              last_row;
  logic              in_range;

  assign n_m1     = n_q - DATA_W'(1);
  assign last_col = (DATA_W'(col_q) == n_m1);
  assign last_row = (DATA_W'(row_q) == n_m1);
  // In range implies both indices are below MAX_N, so the truncation is safe.
  assign in_range = (i < n_q) && (j < n_q);

  assign ram_waddr = AW'(int'(row_q) * MAX_N + int'(col_q));
  assign ram_raddr = AW'(int'(i[IW-1:0]) * MAX_N + int'(j[IW-1:0]));

  det_mat_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (load_data),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Next-state, load sequencing, result capture and sticky error flags.
  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    row_d          = row_q;
    col_d          = col_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    load_err_d     = load_err_q;
    addr_err_d     = addr_err_q;
    ram_we         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_valid && load_ready_q) begin
          if (load_data == '0 || load_data > DATA_W'(MAX_N)) begin
            load_err_d = 1'b1;
          end else begin
            n_d        = load_data;
            row_d      = '0;
            col_d      = '0;
            load_err_d = 1'b0;
            addr_err_d = 1'b0;
            state_d    = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (load_valid && load_ready_q) begin
          ram_we = 1'b1;
          if (last_col) begin
            col_d = '0;
            if (last_row) state_d = ST_HDR;
            else          row_d   = row_q + IW'(1);
          end else begin
            col_d = col_q + IW'(1);
          end
        end
      end
      ST_HDR: begin
        state_d = ST_SERVE;
      end
      ST_SERVE: begin
        if (read && !in_range) addr_err_d = 1'b1;
        if (finish && write) begin
          result_d       = write_data;
          result_valid_d = 1'b1;
          state_d        = ST_DONE;
        end
      end
      ST_DONE: begin
        if (result_ack) begin
          result_valid_d = 1'b0;
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    load_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    eng_reset_d  = !((state_d == ST_HDR) || (state_d == ST_SERVE));
  end

  // Engine read mux: N during the header cycle, entry (i,j) while serving.
  always_comb begin
    read_data = '0;
    case (state_q)
      ST_HDR:   read_data = n_q;
      ST_SERVE: read_data = in_range ? ram_rdata : '0;
      default:  read_data = '0;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      n_q            <= '0;
      row_q          <= '0;
      col_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      load_err_q     <= 1'b0;
      addr_err_q     <= 1'b0;
      load_ready_q   <= 1'b1;
      eng_reset_q    <= 1'b1;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      row_q          <= row_d;
      col_q          <= col_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      load_err_q     <= load_err_d;
      addr_err_q     <= addr_err_d;
      load_ready_q   <= load_ready_d;
      eng_reset_q    <= eng_reset_d;
    end
  end

  assign load_ready   = load_ready_q;
  assign eng_reset    = eng_reset_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign load_err     = load_err_q;
  assign addr_err     = addr_err_q;

`ifdef DET_MAT_MEM_CYCLE_CNT_EN
  logic [31:0] cyc_q, cyc_d;

  // Restart on entry to HDR, count HDR and SERVE cycles, saturate, else hold.
  always_comb begin
    cyc_d = cyc_q;
    if (state_q == ST_LOAD && state_d == ST_HDR) begin
      cyc_d = '0;
    end else if ((state_q == ST_HDR || state_q == ST_SERVE) && cyc_q != '1) begin
      cyc_d = cyc_q + 32'd1;
    end
  end

  // Cycle counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cyc_q <= '0;
    else       cyc_q <= cyc_d;
  end

  assign cycle_count = cyc_q;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_det_mat_mem.sv
// Self-checking bench: the bench plays host and determinant engine.
module tb_det_mat_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic [19:0] load_data;
  logic        eng_reset;
  logic [19:0] i, j;
  logic        read, write;
  logic [19:0] read_data;
  logic [39:0] write_data;
  logic        finish;
  logic [39:0] result;
  logic        result_valid;
  logic        result_ack;
  logic        load_err, addr_err;
  logic [31:0] cycle_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  det_mat_mem #(.MAX_N(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_data    (load_data),
    .eng_reset    (eng_reset),
    .i            (i),
    .j            (j),
    .read         (read),
    .write        (write),
    .read_data    (read_data),
    .write_data   (write_data),
    .finish       (finish),
    .result       (result),
    .result_valid (result_valid),
    .result_ack   (result_ack),
    .load_err     (load_err),
    .addr_err     (addr_err),
    .cycle_count  (cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [19:0]      n;
    logic [8:0][19:0] e;
    logic [39:0]      det;
  } vec_t;

  vec_t vecs [6];

  function automatic vec_t mk(int n, logic [39:0] det, int e0, int e1, int e2,
                              int e3, int e4, int e5, int e6, int e7, int e8);
    vec_t v;
    v.n    = 20'(n);
    v.det  = det;
    v.e[0] = 20'(e0); v.e[1] = 20'(e1); v.e[2] = 20'(e2);
    v.e[3] = 20'(e3); v.e[4] = 20'(e4); v.e[5] = 20'(e5);
    v.e[6] = 20'(e6); v.e[7] = 20'(e7); v.e[8] = 20'(e8);
    return v;
  endfunction

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    load_valid = 1'b0; load_data = '0; i = '0; j = '0;
    read = 1'b0; write = 1'b0; write_data = '0; finish = 1'b0; result_ack = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " load_ready"},   40'(load_ready),   40'd1);
    chk({tag, " eng_reset"},    40'(eng_reset),    40'd1);
    chk({tag, " result"},       result,            40'd0);
    chk({tag, " result_valid"}, 40'(result_valid), 40'd0);
    chk({tag, " load_err"},     40'(load_err),     40'd0);
    chk({tag, " addr_err"},     40'(addr_err),     40'd0);
    chk({tag, " cycle_count"},  40'(cycle_count),  40'd0);
  endtask

  // Full load, engine pass (reads every entry, computes the determinant),
  // result check and acknowledge.
  task automatic run_vec(input int idx, input vec_t v);
    longint a [3][3];
    longint d;
    int     n;
    int     exp_cyc;
    string  tag;
    n   = int'(v.n);
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    load_valid = 1'b1; load_data = v.n;
    for (int k = 0; k < n * n; k++) begin
      @(negedge clk);
      load_data = v.e[k];
    end
    @(negedge clk);
    load_valid = 1'b0; i = 20'd5; j = 20'd7;
    #1;
    chk({tag, " hdr read_data"},  40'(read_data),   40'(v.n));
    chk({tag, " hdr eng_reset"},  40'(eng_reset),   40'd0);
    chk({tag, " hdr load_ready"}, 40'(load_ready),  40'd0);
    chk({tag, " hdr addr_err"},   40'(addr_err),    40'd0);
    chk({tag, " hdr cycle_cnt"},  40'(cycle_count), 40'd0);
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        @(negedge clk);
        read = 1'b1; i = 20'(r); j = 20'(c);
        #1;
        a[r][c] = longint'($signed(read_data));
      end
    end
    if (n == 1)      d = a[0][0];
    else if (n == 2) d = a[0][0] * a[1][1] - a[0][1] * a[1][0];
    else             d = a[0][0] * (a[1][1] * a[2][2] - a[1][2] * a[2][1])
                       - a[0][1] * (a[1][0] * a[2][2] - a[1][2] * a[2][0])
                       + a[0][2] * (a[1][0] * a[2][1] - a[1][1] * a[2][0]);
    @(negedge clk);
    read = 1'b0; write = 1'b1; finish = 1'b1; write_data = 40'(d);
    @(negedge clk);
    write = 1'b0; finish = 1'b0; write_data = '0;
    #1;
`ifdef DET_MAT_MEM_CYCLE_CNT_EN
    exp_cyc = n * n + 2;
`else
    exp_cyc = 0;
`endif
    chk({tag, " result"},       result,            v.det);
    chk({tag, " result_valid"}, 40'(result_valid), 40'd1);
    chk({tag, " done eng_rst"}, 40'(eng_reset),    40'd1);
    chk({tag, " cycle_count"},  40'(cycle_count),  40'(exp_cyc));
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    #1;
    chk({tag, " ack valid"},    40'(result_valid), 40'd0);
    chk({tag, " ack ready"},    40'(load_ready),   40'd1);
  endtask

  initial begin
    vecs[0] = mk(2, 40'd10,           3,  1, 2, 4, 0, 0, 0, 0, 0);
    vecs[1] = mk(1, 40'hFFFFFFFFF9,  -7,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[2] = mk(2, 40'hFFFFFFFFEA,  -5,  3, 4, 2, 0, 0, 0, 0, 0);
    vecs[3] = mk(3, 40'd6,            2,  0, 1, 1, 3, 2, 1, 1, 2);
    vecs[4] = mk(3, 40'd1,            1,  2, 3, 0, 1, 4, 5, 6, 0);
    vecs[5] = mk(2, 40'd10000000000,  100000, 0, 0, 100000, 0, 0, 0, 0, 0);

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_values("rst");
    chk("rst read_data", 40'(read_data), 40'd0);

    // Invalid dimensions: N=0 then N=9.
    @(negedge clk);
    load_valid = 1'b1; load_data = 20'd0;
    @(negedge clk);
    load_data = 20'd9;
    #1;
    chk("n0 load_err",   40'(load_err),   40'd1);
    chk("n0 load_ready", 40'(load_ready), 40'd1);
    @(negedge clk);
    load_valid = 1'b0;
    #1;
    chk("n9 load_err",   40'(load_err),   40'd1);
    chk("n9 load_ready", 40'(load_ready), 40'd1);
    chk("n9 eng_reset",  40'(eng_reset),  40'd1);

    // Still in IDLE: the next word is taken as a dimension.
    @(negedge clk);
    load_valid = 1'b1; load_data = 20'd2;
    @(negedge clk);
    load_data = 20'd3;
    #1;
    chk("dim clears load_err", 40'(load_err), 40'd0);
    @(negedge clk); load_data = 20'd1;
    @(negedge clk); load_data = 20'd2;
    @(negedge clk); load_data = 20'd4;
    @(negedge clk);
    load_valid = 1'b0;
    #1;
    chk("seq hdr read_data", 40'(read_data), 40'd2);
    @(negedge clk);
    read = 1'b1; i = 20'd2; j = 20'd0;
    #1;
    chk("oob read_data", 40'(read_data), 40'd0);
    chk("oob addr_err pre", 40'(addr_err), 40'd0);
    @(negedge clk);
    i = 20'd1; j = 20'd1; write = 1'b1; write_data = 40'd123;
    #1;
    chk("oob addr_err", 40'(addr_err), 40'd1);
    chk("serve (1,1)", 40'(read_data), 40'd4);
    @(negedge clk);
    write = 1'b0; i = 20'd0; j = 20'd1;
    #1;
    chk("write no finish valid", 40'(result_valid), 40'd0);
    chk("write no finish eng", 40'(eng_reset), 40'd0);
    chk("serve (0,1)", 40'(read_data), 40'd1);
    @(negedge clk);
    read = 1'b0; write = 1'b1; finish = 1'b1; write_data = 40'd10;
    @(negedge clk);
    write = 1'b0; finish = 1'b0; write_data = '0;
    load_valid = 1'b1; load_data = 20'd2;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("hold%0d result", c), result, 40'd10);
      chk($sformatf("hold%0d valid", c), 40'(result_valid), 40'd1);
      chk($sformatf("hold%0d ready", c), 40'(load_ready), 40'd0);
      @(negedge clk);
    end
    load_valid = 1'b0;
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    #1;
    chk("ack valid", 40'(result_valid), 40'd0);
    chk("ack ready", 40'(load_ready), 40'd1);
    chk("addr_err sticky", 40'(addr_err), 40'd1);

    for (int v = 0; v < 6; v++) run_vec(v, vecs[v]);

    // Reset after 3 of 4 entries.
    @(negedge clk);
    load_valid = 1'b1; load_data = 20'd2;
    @(negedge clk); load_data = 20'd3;
    @(negedge clk); load_data = 20'd1;
    @(negedge clk); load_data = 20'd2;
    @(negedge clk);
    load_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_values("midload");
    @(negedge clk);
    reset = 1'b0;
    run_vec(6, vecs[0]);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
